fifo4_ctrl: RTL and testbench
=============================

Name: fifo4_ctrl

Overview:
- Control and storage stage of the 4-deep FIFO. It owns the data storage, the occupancy tracking, the status flags and the registered read port.
- Converts raw push/pop requests into accepted write/read events.
- Exposes the read pointer in the same encoding as the occupancy counter: empty = all-ones, otherwise occupancy-1.
- Sits between the producer interface and the consumer of dout.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 4, number of storage entries; fixed at 4 for this release, flags and pointer widths sized for it.
- PTR_W, 4, width of rd_ptr and the occupancy register.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- wr_en  in  1  push request, sampled on clk.
- din  in  WIDTH  push data, valid with wr_en.
- rd_en  in  1  pop request, sampled on clk.
- clr_err  in  1  synchronous clear of the sticky error flags.
- dout  out  WIDTH  registered pop data.
- dout_valid  out  1  one-cycle pulse, dout holds popped word.
- full  out  1  occupancy == DEPTH.
- empty  out  1  occupancy == 0.
- almost_full  out  1  occupancy == DEPTH-1.
- rd_ptr  out  PTR_W  occupancy-1 (4'hF when empty); index of oldest entry.
- overflow  out  1  sticky: push rejected.
- underflow  out  1  sticky: pop while empty.

Behaviour:
- Reset (reset=0, async):
  - occupancy=0, rd_ptr=4'hF, all storage entries=0.
  - dout=0, dout_valid=0, overflow=0, underflow=0.
  - Takes effect immediately, mid-operation included; any in-flight pop is discarded.
- Acceptance rules:
  - rd_acc = rd_en & ~empty.
  - wr_acc = wr_en & (~full | rd_acc). A push while full is accepted only if a pop is accepted in the same cycle.
- Storage is a shift register:
  - On wr_acc, mem[i] <= mem[i-1] for i=1..3, and mem[0] <= din.
  - Oldest word is always at mem[occupancy-1].
- Pop:
  - On rd_acc, dout <= mem[occupancy-1], using pre-shift contents, and dout_valid <= 1.
  - Otherwise dout_valid <= 0 and dout holds its value.
  - Latency: pop request to data is 1 clk.
- Occupancy update:
  - +1 on wr_acc only.
  - -1 on rd_acc only.
  - Unchanged on both or neither.
  - Never wraps: saturation is guaranteed by the acceptance rules.
- Simultaneous push+pop:
  - Empty: push accepted, pop rejected (underflow set), occupancy 0->1, no dout_valid. No fall-through.
  - Full: both accepted, occupancy stays 4, dout = oldest word, din enters mem[0].
- Flags:
  - full, empty, almost_full and rd_ptr are decoded combinationally from the occupancy register.
  - They are registered-state derived, with no input-to-output combinational path.
- Errors:
  - overflow <= 1 when wr_en & ~wr_acc.
  - underflow <= 1 when rd_en & empty.
  - clr_err clears both on the next edge. A new error event in the same cycle as clr_err wins (flag stays 1).
- Rejected operations leave storage, occupancy and dout unchanged.

Decomposition:
- Shared package fifo_pkg holds:
  - DEPTH and WIDTH defaults.
  - PTR_EMPTY = 4'hF.
  - Occupancy type (4-bit).
- One natural sub-module: fifo4_store. It contains the shift-register storage array with a shift enable and a read-index mux.
- Control, flags and error logic stay in fifo4_ctrl.

Test Plan:
- Reset, then push 0x11,0x22,0x33,0x44 on 4 consecutive cycles -> full=1, rd_ptr=3, almost_full asserted after the 3rd push, empty=0.
- From full, pop 4 times -> dout_valid pulses with dout 0x11,0x22,0x33,0x44, 1 cycle after each rd_en; then empty=1, rd_ptr=4'hF.
- Full + wr_en=1 din=0x55 + rd_en=1 -> dout=0x11, occupancy stays 4, and the next 4 pops return 0x22,0x33,0x44,0x55.
- Push while full with no pop -> overflow=1, contents unchanged. rd_en while empty -> underflow=1, dout_valid=0. clr_err -> both 0 next cycle. clr_err with a coincident underflow event -> underflow stays 1.
- Empty + wr_en=1 din=0xA5 + rd_en=1 -> occupancy=1, underflow=1, no dout_valid; the next pop returns 0xA5.
- Fill 2 entries, assert reset mid-cycle between edges -> outputs go to reset values immediately; after release, empty=1 and the first push/pop returns only new data.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the 4-deep FIFO: default sizes, the occupancy type
// and the read-pointer encoding used when the FIFO is empty.
package fifo_pkg;

    localparam int unsigned FIFO_WIDTH = 8;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned OCC_W      = 4;

    typedef logic [OCC_W-1:0] occ_t;

    // rd_ptr value while empty (occupancy-1 wrapped to all-ones)
    localparam occ_t PTR_EMPTY = 4'hF;

endpackage

// File: rtl/fifo4_store.sv
// Shift-register storage for the 4-deep FIFO.
// Ports:
//   clk      - rising-edge clock
//   reset    - asynchronous active-low reset, clears every entry
//   shift_en - shift all entries up by one and load din into entry 0
//   din      - word entering entry 0 on shift_en
//   rd_idx   - index of the entry presented on rd_data
//   rd_data  - combinational read of entry rd_idx (pre-shift contents)
import fifo_pkg::*;

module fifo4_store #(
    parameter int unsigned WIDTH = FIFO_WIDTH,
    parameter int unsigned DEPTH = FIFO_DEPTH,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] din,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    // Newest word always lands in entry 0; the oldest sits at occupancy-1.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (shift_en) begin
            mem_d[0] = din;
            for (int i = 1; i < DEPTH; i++) begin
                mem_d[i] = mem_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/fifo4_ctrl.sv
// Control and storage stage of the 4-deep FIFO: accepts push/pop requests,
// tracks occupancy, decodes status flags, registers the read port and keeps
// sticky overflow/underflow flags.
// Ports:
//   clk, reset      - clock, asynchronous active-low reset
//   wr_en, din      - push request and data
//   rd_en           - pop request
//   clr_err         - synchronous clear of overflow/underflow
//   dout            - registered pop data
//   dout_valid      - one-cycle pulse when dout carries a popped word
//   full, empty     - occupancy == DEPTH / occupancy == 0
//   almost_full     - occupancy == DEPTH-1
//   rd_ptr          - occupancy-1 (all-ones when empty), index of oldest entry
//   overflow        - sticky, set when a push is rejected
//   underflow       - sticky, set when a pop is requested while empty
import fifo_pkg::*;

module fifo4_ctrl #(
    parameter int unsigned WIDTH = FIFO_WIDTH,
    parameter int unsigned DEPTH = FIFO_DEPTH,
    parameter int unsigned PTR_W = OCC_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    input  logic             rd_en,
    input  logic             clr_err,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic [PTR_W-1:0] rd_ptr,
    output logic             overflow,
    output logic             underflow
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic [PTR_W-1:0] occ_q, occ_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic             rd_acc;
    logic             wr_acc;
    logic [WIDTH-1:0] rd_data;

    // Flags come from the occupancy register only.
    assign empty       = (occ_q == '0);
    assign full        = (occ_q == PTR_W'(DEPTH));
    assign almost_full = (occ_q == PTR_W'(DEPTH - 1));
    assign rd_ptr      = empty ? PTR_W'(PTR_EMPTY) : (occ_q - PTR_W'(1));

    // A push into a full FIFO is fine when a pop frees a slot the same cycle.
    assign rd_acc = rd_en & ~empty;
    assign wr_acc = wr_en & (~full | rd_acc);

    fifo4_store #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_store (
        .clk      (clk),
        .reset    (reset),
        .shift_en (wr_acc),
        .din      (din),
        .rd_idx   (rd_ptr[IDX_W-1:0]),
        .rd_data  (rd_data)
    );

    always_comb begin
        occ_d = occ_q;
        unique case ({wr_acc, rd_acc})
            2'b10:   occ_d = occ_q + PTR_W'(1);
            2'b01:   occ_d = occ_q - PTR_W'(1);
            default: occ_d = occ_q;
        endcase

        // rd_data reflects pre-shift contents, so a concurrent push is safe.
        dout_d       = rd_acc ? rd_data : dout_q;
        dout_valid_d = rd_acc;

        // A new error event beats a coincident clear.
        overflow_d  = (overflow_q & ~clr_err) | (wr_en & ~wr_acc);
        underflow_d = (underflow_q & ~clr_err) | (rd_en & empty);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            occ_q        <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            occ_q        <= occ_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;

endmodule

// File: tb/tb_fifo4_ctrl.sv
module tb_fifo4_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [7:0] din;
    logic       rd_en;
    logic       clr_err;
    logic [7:0] dout;
    logic       dout_valid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic [3:0] rd_ptr;
    logic       overflow;
    logic       underflow;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q [$];

    fifo4_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .din         (din),
        .rd_en       (rd_en),
        .clr_err     (clr_err),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .rd_ptr      (rd_ptr),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock of stimulus; returns #1 after the edge with inputs idle.
    task automatic drive(input logic wr, input logic [7:0] d, input logic rd, input logic clr);
        wr_en   = wr;
        din     = d;
        rd_en   = rd;
        clr_err = clr;
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        clr_err = 1'b0;
    endtask

    task automatic push(input logic [7:0] d);
        drive(1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic pop(input logic [7:0] exp);
        exp_q.push_back(exp);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    // Monitor: every dout_valid pulse must match the next expected word.
    always @(negedge clk) begin
        if (dout_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_dout_valid: got dout=%0h expected no pulse", dout);
            end else begin
                chk("dout", {24'h0, dout}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset   = 1'b0;
        wr_en   = 1'b0;
        din     = 8'h00;
        rd_en   = 1'b0;
        clr_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_af", almost_full, 0);
        chk("rst_rd_ptr", rd_ptr, 4'hF);
        chk("rst_dout", dout, 0);
        chk("rst_dout_valid", dout_valid, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_unf", underflow, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Fill
        push(8'h11);
        chk("f1_empty", empty, 0);
        chk("f1_rd_ptr", rd_ptr, 0);
        chk("f1_af", almost_full, 0);
        push(8'h22);
        chk("f2_rd_ptr", rd_ptr, 1);
        push(8'h33);
        chk("f3_af", almost_full, 1);
        chk("f3_rd_ptr", rd_ptr, 2);
        chk("f3_full", full, 0);
        push(8'h44);
        chk("f4_full", full, 1);
        chk("f4_af", almost_full, 0);
        chk("f4_rd_ptr", rd_ptr, 3);
        chk("f4_empty", empty, 0);

        // Drain in order
        pop(8'h11);
        pop(8'h22);
        pop(8'h33);
        pop(8'h44);
        chk("d_empty", empty, 1);
        chk("d_rd_ptr", rd_ptr, 4'hF);
        chk("d_unf", underflow, 0);

        // Simultaneous push+pop while full
        push(8'h11);
        push(8'h22);
        push(8'h33);
        push(8'h44);
        exp_q.push_back(8'h11);
        drive(1'b1, 8'h55, 1'b1, 1'b0);
        chk("pp_full", full, 1);
        chk("pp_rd_ptr", rd_ptr, 3);
        chk("pp_ovf", overflow, 0);
        pop(8'h22);
        pop(8'h33);
        pop(8'h44);
        pop(8'h55);
        chk("pp_empty", empty, 1);

        // Overflow, underflow and clearing
        push(8'hA1);
        push(8'hA2);
        push(8'hA3);
        push(8'hA4);
        push(8'h99);
        chk("ovf_set", overflow, 1);
        chk("ovf_full", full, 1);
        pop(8'hA1);
        pop(8'hA2);
        pop(8'hA3);
        pop(8'hA4);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        chk("unf_set", underflow, 1);
        chk("unf_dout_valid", dout_valid, 0);
        chk("unf_dout_hold", dout, 8'hA4);
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        chk("clr_ovf", overflow, 0);
        chk("clr_unf", underflow, 0);
        drive(1'b0, 8'h00, 1'b1, 1'b1);
        chk("clr_vs_unf", underflow, 1);
        chk("clr_vs_ovf", overflow, 0);
        drive(1'b0, 8'h00, 1'b0, 1'b1);

        // Push+pop while empty: no fall-through
        drive(1'b1, 8'hA5, 1'b1, 1'b0);
        chk("pe_empty", empty, 0);
        chk("pe_rd_ptr", rd_ptr, 0);
        chk("pe_unf", underflow, 1);
        chk("pe_dout_valid", dout_valid, 0);
        pop(8'hA5);
        chk("pe_after_empty", empty, 1);
        drive(1'b0, 8'h00, 1'b0, 1'b1);

        // Asynchronous reset mid-cycle with a pop in flight
        push(8'h01);
        push(8'h02);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        chk("inflight_valid", dout_valid, 1);
        chk("inflight_dout", dout, 8'h01);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_dout", dout, 0);
        chk("ar_dout_valid", dout_valid, 0);
        chk("ar_empty", empty, 1);
        chk("ar_full", full, 0);
        chk("ar_rd_ptr", rd_ptr, 4'hF);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("post_empty", empty, 1);
        push(8'h77);
        pop(8'h77);
        chk("post_end_empty", empty, 1);

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
